// File: rtl/fir_tap_mult_7x8_if.sv
// Sample/coefficient input bus and registered product outputs of the
// seven-tap FIR delay line multiplier.
interface fir_tap_mult_7x8_if;
    logic        clr;
    logic [7:0]  din;
    logic        din_valid;
    logic        coef_wr;
    logic [2:0]  coef_addr;
    logic [7:0]  coef_data;
    logic [15:0] a0, a1, a2, a3, a4, a5, a6;
    logic        prod_valid;
    logic        primed;

    modport master (
        output clr, din, din_valid, coef_wr, coef_addr, coef_data,
        input  a0, a1, a2, a3, a4, a5, a6, prod_valid, primed
    );

    modport slave (
        input  clr, din, din_valid, coef_wr, coef_addr, coef_data,
        output a0, a1, a2, a3, a4, a5, a6, prod_valid, primed
    );
endinterface

// File: rtl/fir_tap_mult_7x8.sv
// Seven-tap sample delay line with a registered per-tap 8x8 coefficient
// multiply. Products feed the downstream adder cascade directly.

// One tap lane: registered tap * coef product.
module fir_tap_lane (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  tap,
    input  logic [7:0]  coef,
    output logic [15:0] prod
);
    // Product register: loads on a stage-2 valid, flushed by clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            prod <= '0;
        else if (clr)
            prod <= '0;
        else if (en)
            prod <= {8'd0, tap} * {8'd0, coef};
    end
endmodule

module fir_tap_mult_7x8 #(
    parameter int NTAPS = 7
) (
    input  logic               clk,
    input  logic               rst,
    fir_tap_mult_7x8_if.slave  bus
);
    localparam int STAGES = 2;

    logic [NTAPS-1:0][7:0]  tap;
    logic [NTAPS-1:0][7:0]  coef;
    logic [NTAPS-1:0][15:0] prod;
    logic [STAGES:0]        vld_pipe;
    logic [2:0]             cnt;

    // A sample is accepted only when no flush is requested in the same cycle.
    assign vld_pipe[0] = bus.din_valid & ~bus.clr;

    // Delay line: newest sample enters tap 0, oldest falls off tap 6.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tap <= '0;
        else if (bus.clr)
            tap <= '0;
        else if (vld_pipe[0])
            tap <= {tap[NTAPS-2:0], bus.din};
    end

    // Valid shift register; clr cancels anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            vld_pipe[STAGES:1] <= '0;
        else if (bus.clr)
            vld_pipe[STAGES:1] <= '0;
        else
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
    end

    // Coefficient file: address 7 matches no entry, so it is silently dropped.
    // Writes ignore clr so a flush never loses programming.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            coef <= '0;
        else if (bus.coef_wr)
            for (int k = 0; k < NTAPS; k++)
                if (bus.coef_addr == 3'(k))
                    coef[k] <= bus.coef_data;
    end

    // Fill counter, saturating once the delay line holds real samples everywhere.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (bus.clr)
            cnt <= '0;
        else if (vld_pipe[0] && cnt != 3'd7)
            cnt <= cnt + 3'd1;
    end

    fir_tap_lane u_lane [NTAPS-1:0] (
        .clk  (clk),
        .rst  (rst),
        .clr  (bus.clr),
        .en   (vld_pipe[1]),
        .tap  (tap),
        .coef (coef),
        .prod (prod)
    );

    assign bus.a0         = prod[0];
    assign bus.a1         = prod[1];
    assign bus.a2         = prod[2];
    assign bus.a3         = prod[3];
    assign bus.a4         = prod[4];
    assign bus.a5         = prod[5];
    assign bus.a6         = prod[6];
    assign bus.prod_valid = vld_pipe[STAGES];
    assign bus.primed     = (cnt == 3'd7);
endmodule

// File: tb/tb_fir_tap_mult_7x8.sv
// Scoreboard bench: stimulus pushes hand-computed product sets, a negedge
// monitor pops and compares on every prod_valid pulse.
module tb_fir_tap_mult_7x8;
    typedef logic [6:0][15:0] pset_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    fir_tap_mult_7x8_if bus();

    fir_tap_mult_7x8 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int    checks   = 0;
    int    failures = 0;
    pset_t exp_q[$];
    pset_t last     = '0;
    logic  hold_en  = 1'b0;

    function automatic pset_t outs();
        return {bus.a6, bus.a5, bus.a4, bus.a3, bus.a2, bus.a1, bus.a0};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Monitor: compare each fresh product set; during gaps outputs must hold.
    always @(negedge clk) begin
        pset_t e;
        if (!rst) begin
            if (bus.prod_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse actual=%0h required=none", outs());
                end else begin
                    e = exp_q.pop_front();
                    chk("product_set", outs(), e);
                end
                last = outs();
            end else if (hold_en) begin
                chk("gap_hold", outs(), last);
            end
        end
    end

    task automatic cyc(input logic dv, input logic [7:0] d,
                       input logic wr = 1'b0, input logic [2:0] ad = 3'd0,
                       input logic [7:0] cd = 8'd0, input logic cl = 1'b0);
        bus.din_valid = dv;
        bus.din       = d;
        bus.coef_wr   = wr;
        bus.coef_addr = ad;
        bus.coef_data = cd;
        bus.clr       = cl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        pset_t e;
        int    c[7];
        bus.clr = 0; bus.din = 0; bus.din_valid = 0;
        bus.coef_wr = 0; bus.coef_addr = 0; bus.coef_data = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_prod", outs(), '0);
        chk("reset_valid", bus.prod_valid, 0);
        chk("reset_primed", bus.primed, 0);
        rst = 0;
        cyc(0, 0);

        // Impulse response with coefficients 1..7
        for (int k = 0; k < 7; k++) cyc(0, 0, 1, 3'(k), 8'(k + 1));
        for (int i = 0; i < 7; i++) begin
            e = '0; e[i] = 16'(10 * (i + 1)); exp_q.push_back(e);
        end
        cyc(1, 10);
        chk("impulse_primed_0", bus.primed, 0);
        for (int i = 1; i < 7; i++) begin
            cyc(1, 0);
            chk("impulse_valid_cont", bus.prod_valid, 1);
            chk("impulse_primed", bus.primed, (i == 6));
        end
        cyc(0, 0);
        chk("impulse_valid_last", bus.prod_valid, 1);
        cyc(0, 0);
        chk("impulse_valid_end", bus.prod_valid, 0);

        // Full-scale arithmetic
        for (int k = 0; k < 7; k++) cyc(0, 0, 1, 3'(k), 8'd255);
        for (int j = 1; j <= 7; j++) begin
            for (int k = 0; k < 7; k++) e[k] = (k < j) ? 16'hFE01 : 16'h0;
            exp_q.push_back(e);
        end
        for (int j = 0; j < 7; j++) cyc(1, 255);
        cyc(0, 0);
        cyc(0, 0);
        chk("fullscale_final", outs(), {7{16'hFE01}});

        // Gapped input: taps start at all-255
        hold_en = 1;
        for (int s = 1; s <= 3; s++) begin
            for (int k = 0; k < 7; k++) e[k] = (k < s) ? 16'((s - k) * 255) : 16'hFE01;
            exp_q.push_back(e);
            cyc(1, 8'(s));
            chk("gap_valid_low", bus.prod_valid, 0);
            cyc(0, 0);
            chk("gap_valid_pulse", bus.prod_valid, 1);
        end
        cyc(0, 0);
        hold_en = 0;

        // Coefficient timing: taps 3,2,1,255,255,255,255 beforehand
        e = '0;
        e[0] = 1020; e[1] = 765; e[2] = 510; e[3] = 9; e[4] = 16'hFE01; e[5] = 16'hFE01; e[6] = 16'hFE01;
        exp_q.push_back(e);
        e[0] = 1275; e[1] = 1020; e[2] = 765; e[3] = 18; e[4] = 255; e[5] = 16'hFE01; e[6] = 16'hFE01;
        exp_q.push_back(e);
        e[0] = 1530; e[1] = 1275; e[2] = 1020; e[3] = 27; e[4] = 510; e[5] = 255; e[6] = 16'hFE01;
        exp_q.push_back(e);
        cyc(1, 4, 1, 3'd3, 8'd9);
        cyc(1, 5, 1, 3'd7, 8'd0);
        cyc(1, 6);
        cyc(0, 0, 1, 3'd0, 8'd2);
        cyc(0, 0);

        // clr collision with a pending product update
        chk("clr_pre_primed", bus.primed, 1);
        cyc(1, 7);
        cyc(1, 8, 0, 3'd0, 8'd0, 1);
        chk("clr_prod", outs(), '0);
        chk("clr_valid", bus.prod_valid, 0);
        chk("clr_primed", bus.primed, 0);
        c = '{2, 255, 255, 9, 255, 255, 255};
        for (int j = 1; j <= 7; j++) begin
            for (int k = 0; k < 7; k++) e[k] = (k < j) ? 16'((j - k) * c[k]) : 16'h0;
            exp_q.push_back(e);
        end
        for (int j = 1; j <= 7; j++) begin
            cyc(1, 8'(j));
            chk("refill_primed", bus.primed, (j == 7));
        end
        cyc(0, 0);
        cyc(0, 0);

        // Mid-stream asynchronous reset; taps 7,6,5,4,3,2,1 beforehand
        e[0] = 18; e[1] = 1785; e[2] = 1530; e[3] = 45; e[4] = 1020; e[5] = 765; e[6] = 510;
        exp_q.push_back(e);
        cyc(1, 9);
        cyc(1, 9);
        chk("pre_rst_valid", bus.prod_valid, 1);
        #5;
        rst = 1;
        #1;
        chk("async_rst_prod", outs(), '0);
        chk("async_rst_valid", bus.prod_valid, 0);
        chk("async_rst_primed", bus.primed, 0);
        bus.din_valid = 0;
        @(posedge clk);
        #1;
        rst = 0;
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0);
            chk("post_rst_prod", outs(), '0);
            chk("post_rst_valid", bus.prod_valid, 0);
            chk("post_rst_primed", bus.primed, 0);
        end

        // Coefficients were cleared by reset: a sample yields a zero product set
        exp_q.push_back('0);
        cyc(1, 5);
        cyc(0, 0);
        cyc(0, 0);
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
